i2c_target: RTL
===============

Name: i2c_target

Overview:
- I2C responder (target) for 7-bit addressing; the slave end of the team's I2C master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- First byte after address+W sets a register pointer; following bytes write to a simple register interface. Address+R reads from that interface.
- Pointer auto-increments per data byte. SDA is open-drain: the block only ever drives low.

Parameters:
- DEV_ADDR, 7'h50, the 7-bit address this target ACKs.
- SYNC_STAGES, 2, number of input synchronizer flops on scl_in and sda_in (minimum 2).

Ports:
- clk  input  1  system clock. Must be at least 10x the SCL frequency.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  bus SCL, asynchronous.
- sda_in  input  1  bus SDA, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- reg_addr  output  8  register pointer.
- reg_wdata  output  8  write data; valid when reg_we=1.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; sampled exactly 1 clk after reg_re.
- busy  output  1  high from address match until STOP, START-to-other-address, or NACK-terminated read.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, state=IDLE, bit counter=0.
- Reset mid-transfer releases SDA on the next clk edge.
- Synchronized signals are scl_s/sda_s. Edges are found from scl_s versus its previous value.
- Input-to-decision latency is SYNC_STAGES+1 clk.
- START: sda_s falls while scl_s=1. STOP: sda_s rises while scl_s=1. Both are checked every cycle and take priority over bit handling.
- START in any state: release SDA, clear bit counter, go to ADDR.
- STOP in any state: release SDA, busy=0, go to IDLE.
- Bit timing: receive bits are shifted MSB first on scl_s rising. sda_oe changes only on scl_s falling.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If addr[7:1]==DEV_ADDR: busy=1. On the next SCL fall go to ACK_A with sda_oe=1.
    - Otherwise go to IGNORE.
  - IGNORE: sda_oe=0 until START or STOP.
  - ACK_A: hold sda_oe=1 through the ACK clock; release on the following SCL fall.
    - R/W=0: go to RX, with first_byte flag set.
    - R/W=1: pulse reg_re at the ACK SCL rise, latch reg_rdata into the TX shifter, go to TX.
  - RX: shift 8 bits, then go to ACK_RX. sda_oe=1 on the SCL fall after bit 8.
    - first_byte=1: load reg_addr with the byte.
    - first_byte=0: reg_wdata=byte and reg_we=1 for one clk, coincident with sda_oe going high. reg_addr increments on the clk after reg_we.
  - ACK_RX: release SDA after the ACK clock, then go to RX.
  - TX: drive sda_oe=~bit on each SCL fall, MSB first. The first bit is driven on the SCL fall that ends the ACK.
    - After 8 bits, release SDA and go to MACK.
  - MACK: sample master ACK on SCL rise.
    - ACK (0): reg_addr+1, pulse reg_re, load the shifter, go to TX.
    - NACK (1): busy=0, go to IGNORE.
- reg_addr is 8-bit modulo: 8'hFF+1 = 8'h00, no flag.
- Repeated START after the pointer write keeps reg_addr. This supports the write-pointer-then-read sequence.
- General-call address 0x00 is not ACKed unless DEV_ADDR=0.
- A START inside a byte discards the partial byte. No reg_we is issued for it.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronizers on both lines. It adds 2 clk of latency and rejects pulses of 1 clk or less.
- Undefined: synchronizer outputs are used directly.

Decomposition:
- Package i2c_pkg holds:
  - state encoding constants (IDLE, ADDR, IGNORE, ACK_A, RX, ACK_RX, TX, MACK);
  - I2C_RW_READ=1'b1 and I2C_RW_WRITE=1'b0;
  - ACK=1'b0 and NACK=1'b1.
- Sub-module i2c_line_cond covers one line: synchronizer, optional majority filter, rise/fall outputs. It is instantiated for SCL and for SDA.

Test Plan:
- Write 0x50+W, ptr 0x10, data 0xA5, 0x3C, STOP: ACK on all 4 bytes; reg_we pulses with (0x10,0xA5) and (0x11,0x3C); reg_addr=0x12; busy low after STOP.
- Write ptr 0x20, Sr, 0x50+R, reg_rdata model = addr^0xFF, master ACK then NACK: bytes 0xDF, 0xDE on SDA; busy drops after NACK.
- Address 0x51+W: sda_oe never asserts; no reg_we/reg_re; busy stays 0.
- Write ptr 0xFF, data 0x01, 0x02: writes at 0xFF then 0x00 (wrap).
- START after 4 bits of a data byte, then a new full write: no strobe for the partial byte; the new transaction completes normally.
- rst asserted during TX while sda_oe=1: sda_oe=0 on the next clk; all outputs return to reset values. The next transaction works.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target slice.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN is consumed by i2c_line_cond.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    IGNORE,
    ACK_A,
    RX,
    ACK_RX,
    TX,
    MACK
  } i2c_state_e;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// One bus line: synchronizer, optional majority filter, edge detect.
// Macro I2C_TARGET_GLITCH_FILTER_EN enables the 3-sample majority filter.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_s,
  output logic rise,
  output logic fall
);
  import i2c_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_q;

  // Idle bus level is high, so reset the chain to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '1;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign line_s = maj3(hist_q);
`else
  assign line_s = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= 1'b1;
    end else begin
      line_q <= line_s;
    end
  end

  assign rise = line_s & ~line_q;
  assign fall = ~line_s & line_q;

endmodule

// File: rtl/i2c_target.sv
// 7-bit I2C target with register pointer and simple register port.
// Macro I2C_TARGET_GLITCH_FILTER_EN adds a majority filter on SCL/SDA.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  i2c_state_e state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [7:0] rx_q, rx_n;
  logic [7:0] tx_q, tx_n;
  logic       first_q, first_n;
  logic       rw_q, rw_n;
  logic       oe_n, busy_n, we_n, re_n;
  logic [7:0] addr_n, wdata_n;

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start, stop;
  logic [7:0] rx_byte;

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_scl (
    .clk    (clk),
    .rst    (rst),
    .line_in(scl_in),
    .line_s (scl_s),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sda (
    .clk    (clk),
    .rst    (rst),
    .line_in(sda_in),
    .line_s (sda_s),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  assign start   = sda_fall & scl_s;
  assign stop    = sda_rise & scl_s;
  assign rx_byte = {rx_q[6:0], sda_s};

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rx_n    = rx_q;
    tx_n    = tx_q;
    first_n = first_q;
    rw_n    = rw_q;
    oe_n    = sda_oe;
    busy_n  = busy;
    we_n    = 1'b0;
    re_n    = 1'b0;
    addr_n  = reg_addr;
    wdata_n = reg_wdata;

    // Post-write increment and read-data capture trail their strobes by one clk.
    if (reg_we) addr_n = reg_addr + 8'd1;
    if (reg_re) tx_n = reg_rdata;

    unique case (1'b1)
      start: begin
        oe_n    = 1'b0;
        cnt_n   = '0;
        state_n = ADDR;
      end
      stop: begin
        oe_n    = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        unique case (state_q)
          IDLE, IGNORE: begin
            oe_n = 1'b0;
          end
          ADDR: begin
            if (scl_rise && cnt_q != 4'd8) begin
              rx_n  = rx_byte;
              cnt_n = cnt_q + 4'd1;
              if (cnt_q == 4'd7 && rx_byte[7:1] == DEV_ADDR) busy_n = 1'b1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_n = '0;
              rw_n  = rx_q[0];
              if (rx_q[7:1] == DEV_ADDR) begin
                oe_n    = 1'b1;
                state_n = ACK_A;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end
          end
          ACK_A: begin
            // Read: fetch on the ACK rise; TX drives bit 7 on the closing fall.
            if (scl_rise && rw_q == I2C_RW_READ) begin
              re_n    = 1'b1;
              cnt_n   = '0;
              state_n = TX;
            end else if (scl_fall) begin
              oe_n    = 1'b0;
              first_n = 1'b1;
              cnt_n   = '0;
              state_n = RX;
            end
          end
          RX: begin
            if (scl_rise && cnt_q != 4'd8) begin
              rx_n  = rx_byte;
              cnt_n = cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              oe_n    = 1'b1;
              state_n = ACK_RX;
              if (first_q) begin
                addr_n  = rx_q;
                first_n = 1'b0;
              end else begin
                wdata_n = rx_q;
                we_n    = 1'b1;
              end
            end
          end
          ACK_RX: begin
            if (scl_fall) begin
              oe_n    = 1'b0;
              cnt_n   = '0;
              state_n = RX;
            end
          end
          TX: begin
            if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                oe_n    = 1'b0;
                state_n = MACK;
              end else begin
                oe_n  = ~tx_q[7];
                tx_n  = {tx_q[6:0], 1'b0};
                cnt_n = cnt_q + 4'd1;
              end
            end
          end
          MACK: begin
            if (scl_rise) begin
              if (sda_s == ACK) begin
                addr_n  = reg_addr + 8'd1;
                re_n    = 1'b1;
                cnt_n   = '0;
                state_n = TX;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end
          end
          default: state_n = IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      first_q   <= 1'b0;
      rw_q      <= I2C_RW_WRITE;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      rx_q      <= rx_n;
      tx_q      <= tx_n;
      first_q   <= first_n;
      rw_q      <= rw_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
      reg_we    <= we_n;
      reg_re    <= re_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
    end
  end

endmodule
